// File: rtl/ram_group_reader.sv
// ============================================================================
//  ram_group_reader : burst-read initiator for the four-bank ram_group memory
//  Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_group_reader #(
  parameter int AWIDTH     = 10,
  parameter int DWIDTH     = 64,
  parameter int RD_LATENCY = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_bank_i,
  input  logic [AWIDTH-1:0]     cmd_addr_i,
  input  logic [AWIDTH:0]       cmd_len_i,
  output logic [AWIDTH-1:0]     ram_addr_o,
  output logic [3:0]            ram_ce_o,
  output logic [3:0]            ram_we_o,
  input  logic [4*DWIDTH-1:0]   ram_q_i,
  output logic                  dout_valid_o,
  input  logic                  dout_ready_i,
  output logic [DWIDTH-1:0]     dout_data_o,
  output logic                  dout_last_o,
  output logic                  busy_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [AWIDTH:0]   REM_ONE = (AWIDTH+1)'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [1:0]            bank_q;
  logic [AWIDTH-1:0]     cur_q;
  logic [AWIDTH-1:0]     addr_q;
  logic [AWIDTH:0]       rem_q;
  logic [CW-1:0]         credit_q;
  logic [RD_LATENCY-1:0] pv_q;
  logic [RD_LATENCY-1:0] pl_q;
  logic [1:0]            pb_q [RD_LATENCY];
  logic [DWIDTH:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         cnt_q;
  logic [DWIDTH-1:0]     q_bank [4];

  logic accept, issue, pop, fifo_wr;

  genvar b;
  generate
    for (b = 0; b < 4; b++) begin : g_bank
      assign q_bank[b] = ram_q_i[b*DWIDTH +: DWIDTH];
    end
  endgenerate

  assign accept  = cmd_valid_i & cmd_ready_o;
  assign issue   = (state_q == S_ISSUE) && (credit_q < DEPTH_C);
  assign pop     = dout_valid_o & dout_ready_i;
  assign fifo_wr = pv_q[RD_LATENCY-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && cmd_len_i != '0) state_d = S_ISSUE;
      S_ISSUE: if (issue && rem_q == REM_ONE) state_d = S_DRAIN;
      S_DRAIN: if (pop && dout_last_o)        state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = (state_q == S_IDLE);
    busy_o      = (state_q != S_IDLE);
    ram_we_o    = 4'b0000;
    ram_ce_o    = issue ? (4'b0001 << bank_q) : 4'b0000;
    ram_addr_o  = issue ? cur_q : addr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_q <= '0;
      cur_q  <= '0;
      addr_q <= '0;
      rem_q  <= '0;
    end else if (accept) begin
      bank_q <= cmd_bank_i;
      cur_q  <= cmd_addr_i;
      rem_q  <= cmd_len_i;
    end else if (issue) begin
      cur_q  <= cur_q + 1'b1;
      rem_q  <= rem_q - 1'b1;
      addr_q <= cur_q;
    end
  end

  // Return tracker mirrors the bank read latency so the tail lines up with ram_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv_q <= '0;
      pl_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pb_q[i] <= '0;
    end else begin
      pv_q[0] <= issue;
      pl_q[0] <= (rem_q == REM_ONE);
      pb_q[0] <= bank_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pl_q[i] <= pl_q[i-1];
        pb_q[i] <= pb_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_q <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   credit_q <= credit_q + 1'b1;
        2'b01:   credit_q <= credit_q - 1'b1;
        default: credit_q <= credit_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (fifo_wr) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      case ({fifo_wr, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_wr) fifo_mem[wptr_q] <= {pl_q[RD_LATENCY-1], q_bank[pb_q[RD_LATENCY-1]]};
  end

  always_comb begin
    dout_valid_o = (cnt_q != '0);
    dout_data_o  = dout_valid_o ? fifo_mem[rptr_q][DWIDTH-1:0] : '0;
    dout_last_o  = dout_valid_o ? fifo_mem[rptr_q][DWIDTH]     : 1'b0;
  end

endmodule

`default_nettype wire

// File: doc/ram_group_reader.md
# ram_group_reader

Read-side initiator for the four-bank `ram_group` memory. It accepts a burst-read command (bank, start address, length), issues one read per cycle on port 0 of the selected bank, and tracks the fixed 3-cycle bank read latency. Returned words land in a local FIFO and leave on a valid/ready stream with a last flag. Credit-based issue guarantees no returned word is ever dropped under downstream backpressure.

## Interface
- AWIDTH, 10, word address width per bank.
- DWIDTH, 64, data word width.
- RD_LATENCY, 3, cycles from `ram_ce` asserted to valid `ram_q`. Matches `ram_group`: input pipe, then sync RAM, then output register.
- FIFO_DEPTH, 8, return FIFO entries; power of two, ≥ RD_LATENCY+1.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_bank  in  2  target bank 0..3.
- cmd_addr  in  AWIDTH  first word address.
- cmd_len  in  AWIDTH+1  word count, 0..2^AWIDTH.
- ram_addr  out  AWIDTH  address broadcast to port-0 addr of all banks.
- ram_ce  out  4  one-hot port-0 enable per bank.
- ram_we  out  4  port-0 write enables, constant 0.
- ram_q  in  4*DWIDTH  port-0 read data; bank b occupies [b*DWIDTH +: DWIDTH].
- dout_valid  out  1  FIFO non-empty.
- dout_ready  in  1  consumer accepts.
- dout_data  out  DWIDTH  head word; 0 when empty.
- dout_last  out  1  head word is the final word of the burst.
- busy  out  1  state ≠ IDLE.

## Operation
- **States:** IDLE, ISSUE, DRAIN.
- **IDLE:**
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch bank, addr, and remaining=cmd_len.
  - If cmd_len≠0, go to ISSUE. If cmd_len=0, accept the command, stay in IDLE, and emit no beats.
- **ISSUE:**
  - Issue is permitted when credit<FIFO_DEPTH, where credit = in-flight reads + FIFO occupancy.
  - On issue: ram_ce[bank]=1, ram_addr=cur, cur←cur+1 (wraps mod 2^AWIDTH; no error), remaining←remaining−1.
  - When credit is exhausted, ram_ce=0 that cycle and nothing advances.
  - The issue with remaining=1 tags the read as last and moves to DRAIN.
- **DRAIN:** go to IDLE in the cycle after the last-tagged beat pops (dout_valid&dout_ready&dout_last).
- **Return pipeline:**
  - Shift register, RD_LATENCY deep, carrying {valid, bank, last}.
  - When the tail entry is valid, write {ram_q slice[bank], last} into the FIFO. Credit guarantees the FIFO is never full at that point.
- **Credit counter (width clog2(FIFO_DEPTH)+1):**
  - +1 on issue, −1 on pop.
  - Simultaneous issue and pop: unchanged.
- ram_addr holds its last value when ram_ce=0.

## Timing
- **Reset values:** state=IDLE, cmd_ready=1, ram_ce=0, ram_addr=0, ram_we=0, dout_valid=0, dout_data=0, dout_last=0, busy=0, credit=0, pipeline valids=0. FIFO storage is not reset.
- **Reset mid-burst:** all in-flight reads and FIFO contents are discarded; the first post-reset cycle is IDLE.
- **Latency:**
  - Handshake at edge E0 → first ram_ce in cycle 1.
  - ram_q valid in cycle 1+RD_LATENCY.
  - FIFO write at the end of that cycle → dout_valid in cycle 2+RD_LATENCY (cycle 5 by default).
- **Throughput:**
  - One word per cycle while dout_ready=1.
  - Under stall, at most FIFO_DEPTH words are outstanding. Issue resumes the cycle after a pop frees credit.
- **FIFO:** first-word-fall-through; dout_data/dout_last are stable while dout_valid&!dout_ready.
- cmd_ready=0 throughout ISSUE and DRAIN; commands are never overlapped.

## Test plan
- **Single word:** bank 2, addr 0x010, len 1, word preloaded 0xA5 → ram_ce=4'b0100 for exactly one cycle with ram_addr=0x010; then dout_valid with data 0xA5 and last=1 in cycle 5; busy falls the cycle after the pop.
- **Full-rate burst:** bank 0, addr 0x3FE, len 4, dout_ready=1 → addresses 0x3FE, 0x3FF, 0x000, 0x001 on consecutive cycles; 4 back-to-back beats; last on beat 4 only.
- **Backpressure:** len 20, dout_ready=0 → exactly 8 issues, then ram_ce=0; data held stable. Release dout_ready → all 20 words in address order, none lost or duplicated.
- **Zero length:** cmd_len=0 → accepted in one cycle; ram_ce stays 0; no dout_valid; busy stays 0.
- **Async reset:** deassert rst_n mid-burst with 3 reads in flight → all outputs go to reset values immediately with no clock edge. After release, a new bank-3 command completes correctly with no stale beats.
- **Random regression:** random bank/addr/len with random dout_ready → scoreboard matches the memory model; credit never exceeds 8.
